// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus the writeback commit into the general register file and HI/LO.
// Read ports bypass the in-flight writeback so ID sees a value one cycle before it is stored.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [ADDR_W-1:0] wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              whilo_q, whilo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] hi_store_q;
    logic [DATA_W-1:0] lo_store_q;

    // A MEM-only stall leaves nothing valid to pass on, so it injects a bubble just like a flush.
    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush || (stall_mem && !stall_wb)) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
        end else if (!stall_mem) begin
            wd_d    = mem_wd;
            wreg_d  = mem_wreg;
            wdata_d = mem_wdata;
            whilo_d = mem_whilo;
            hi_d    = mem_hi;
            lo_d    = mem_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A held bundle during a WB stall simply rewrites the same value each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            hi_store_q <= '0;
            lo_store_q <= '0;
        end else begin
            if (wreg_q && (wd_q != '0)) begin
                regs_q[wd_q] <= wdata_q;
            end
            if (whilo_q) begin
                hi_store_q <= hi_q;
                lo_store_q <= lo_q;
            end
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic re, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (re && (addr != '0)) begin
            if (wreg_q && (wd_q == addr)) begin
                val = wdata_q;
            end else begin
                val = regs_q[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = readPort(re1, raddr1);
        rdata2 = readPort(re2, raddr2);
    end

    assign hi_o = whilo_q ? hi_q : hi_store_q;
    assign lo_o = whilo_q ? lo_q : lo_store_q;

    assign wb_wd    = wd_q;
    assign wb_wreg  = wreg_q;
    assign wb_wdata = wdata_q;
    assign wb_whilo = whilo_q;
    assign wb_hi    = hi_q;
    assign wb_lo    = lo_q;

endmodule
